// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared state encoding and memory-offset selects for the convolution sequencer
package conv_ctrl_pkg;
  typedef enum logic [3:0] {
    IDLE, INIT, LD_FILTER, NEXT_FILTER, LD_SLICE, LD_BUFFER, MAC, LD_RESULT,
    WRITE_MEM, UPDATE, INC_OFFSET, DONE
  } state_t;
  localparam logic [1:0] OFS_FILTER = 2'd0;
  localparam logic [1:0] OFS_IMG    = 2'd1;
  localparam logic [1:0] OFS_OUT    = 2'd2;
endpackage

// File: rtl/conv_wrap_cnt.sv
// conv_wrap_cnt: registered up-counter with clear and a last flag at MAX-1
module conv_wrap_cnt #(
  parameter int CW  = 8,
  parameter int MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);
  // counts only when enabled; returns to zero solely through clr or rst
  always_ff @(posedge clk) cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign last = cnt == CW'(MAX - 1);
endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: convolution datapath sequencer; CONV_PERF_CNT_EN adds perf_cycles/perf_stalls counters
module conv_seq_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int CW          = 8,
  parameter int FILT_CNT    = 4,
  parameter int FILT_WORDS  = 4,
  parameter int SLICE_WORDS = 16,
  parameter int WIN_ROWS    = 4,
  parameter int MAC_STEPS   = 16,
  parameter int RES_PACK    = 4,
  parameter int COLS        = 13,
  parameter int N_RES       = 169
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          mem_gnt,
  output logic          dp_rst,
  output logic          inc_ld,
  output logic          inc_en,
  output logic          adr_sel,
  output logic [1:0]    mem_offset_sel,
  output logic          filter_wr_en,
  output logic          img_wr_en,
  output logic          img_slice_en,
  output logic          acc_en,
  output logic          res_buffer_en,
  output logic          rst_acc,
  output logic          rst_res_reg,
  output logic          mem_en,
  output logic          wr_file,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] filt_idx,
  output logic [CW-1:0] filt_word,
  output logic [CW-1:0] slice_idx,
  output logic [CW-1:0] row_idx,
  output logic [CW-1:0] mac_idx,
  output logic [CW-1:0] col_idx,
  output logic [CW-1:0] res_slot
`ifdef CONV_PERF_CNT_EN
  ,
  output logic [31:0]   perf_cycles,
  output logic [31:0]   perf_stalls
`endif
);
  state_t state, nxt;
  logic fw_last, fi_last, sl_last, row_last, mac_last, rs_last, col_last;
  logic [CW:0] res_num;
  // state register
  always_ff @(posedge clk) state <= rst ? IDLE : nxt;
  // results produced this run; the extra bit keeps N_RES == 2**CW representable
  always_ff @(posedge clk) res_num <= (rst || state == INIT) ? '0 : state == LD_RESULT ? res_num + 1'b1 : res_num;
  // next-state decode; memory states wait for mem_gnt
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = start ? INIT : IDLE;
      INIT:        nxt = start ? INIT : LD_FILTER;
      LD_FILTER:   nxt = (mem_gnt && fw_last) ? NEXT_FILTER : LD_FILTER;
      NEXT_FILTER: nxt = fi_last ? LD_SLICE : LD_FILTER;
      LD_SLICE:    nxt = (mem_gnt && sl_last) ? LD_BUFFER : LD_SLICE;
      LD_BUFFER:   nxt = row_last ? MAC : LD_BUFFER;
      MAC:         nxt = mac_last ? LD_RESULT : MAC;
      LD_RESULT:   nxt = (rs_last || res_num == (CW+1)'(N_RES - 1)) ? WRITE_MEM : UPDATE;
      WRITE_MEM:   nxt = !mem_gnt ? WRITE_MEM : res_num == (CW+1)'(N_RES) ? DONE : UPDATE;
      UPDATE:      nxt = col_last ? INC_OFFSET : LD_BUFFER;
      INC_OFFSET:  nxt = LD_SLICE;
      DONE:        nxt = IDLE;
      default:     nxt = IDLE;
    endcase
  end
  // Moore strobes decoded from the current state only
  always_comb begin
    dp_rst         = state == INIT;
    inc_ld         = state == INIT;
    inc_en         = state == INC_OFFSET;
    adr_sel        = state == LD_FILTER;
    filter_wr_en   = state == LD_FILTER;
    img_wr_en      = state == LD_SLICE;
    img_slice_en   = state == LD_BUFFER;
    acc_en         = state == MAC;
    res_buffer_en  = state == LD_RESULT;
    rst_acc        = state == LD_RESULT;
    mem_en         = state == WRITE_MEM;
    rst_res_reg    = state == WRITE_MEM;
    wr_file        = state == DONE;
    done           = state == DONE;
    busy           = state != IDLE && state != DONE;
    mem_offset_sel = state == LD_SLICE ? OFS_IMG : state == WRITE_MEM ? OFS_OUT : OFS_FILTER;
  end
  conv_wrap_cnt #(.CW(CW), .MAX(FILT_WORDS)) u_fw (
    .clk, .rst, .clr(state == INIT || state == NEXT_FILTER),
    .en(state == LD_FILTER && mem_gnt && !fw_last), .cnt(filt_word), .last(fw_last));
  conv_wrap_cnt #(.CW(CW), .MAX(FILT_CNT)) u_fi (
    .clk, .rst, .clr(state == INIT), .en(state == NEXT_FILTER), .cnt(filt_idx), .last(fi_last));
  conv_wrap_cnt #(.CW(CW), .MAX(SLICE_WORDS)) u_sl (
    .clk, .rst, .clr(state == INIT || state == LD_BUFFER),
    .en(state == LD_SLICE && mem_gnt && !sl_last), .cnt(slice_idx), .last(sl_last));
  conv_wrap_cnt #(.CW(CW), .MAX(WIN_ROWS)) u_row (
    .clk, .rst, .clr(state == INIT || state == MAC),
    .en(state == LD_BUFFER && !row_last), .cnt(row_idx), .last(row_last));
  conv_wrap_cnt #(.CW(CW), .MAX(MAC_STEPS)) u_mac (
    .clk, .rst, .clr(state == INIT || state == LD_RESULT),
    .en(state == MAC && !mac_last), .cnt(mac_idx), .last(mac_last));
  conv_wrap_cnt #(.CW(CW), .MAX(RES_PACK)) u_rs (
    .clk, .rst, .clr(state == INIT || (state == WRITE_MEM && mem_gnt)),
    .en(state == LD_RESULT), .cnt(res_slot), .last(rs_last));
  conv_wrap_cnt #(.CW(CW), .MAX(COLS)) u_col (
    .clk, .rst, .clr(state == INIT || (state == UPDATE && col_last)),
    .en(state == UPDATE && !col_last), .cnt(col_idx), .last(col_last));
`ifdef CONV_PERF_CNT_EN
  logic stall;
  assign stall = (state == LD_FILTER || state == LD_SLICE || state == WRITE_MEM) && !mem_gnt;
  // saturating busy/stall tallies, cleared at run start and frozen once the run ends
  always_ff @(posedge clk) begin
    perf_cycles <= (rst || state == INIT) ? '0 : (busy && !(&perf_cycles)) ? perf_cycles + 1'b1 : perf_cycles;
    perf_stalls <= (rst || state == INIT) ? '0 : (stall && !(&perf_stalls)) ? perf_stalls + 1'b1 : perf_stalls;
  end
`endif
endmodule
